// File: rtl/mod_mul_seq.sv
// Bit-serial modular multiplier: out_data = (opA*opB) mod opM, one multiplier bit per cycle, MSB first.
// Optional operand range check enabled by defining MOD_MUL_RANGE_CHECK_EN.
module mod_mul_seq #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load;
  logic             range_bad;

  // One double-and-add step; sums are WIDTH+1 bits so acc,opA < opM never overflow.
  logic [WIDTH:0]   m_ext, dbl, dbl_r, sum, sum_r;
  logic [WIDTH-1:0] step;

  always_comb begin
    m_ext = {1'b0, m_q};
    dbl   = {acc_q, 1'b0};
    dbl_r = (dbl >= m_ext) ? dbl - m_ext : dbl;
    sum   = dbl_r + {1'b0, a_q};
    sum_r = (sum >= m_ext) ? sum - m_ext : sum;
    step  = b_q[cnt_q] ? sum_r[WIDTH-1:0] : dbl_r[WIDTH-1:0];
  end

`ifdef MOD_MUL_RANGE_CHECK_EN
  logic err_q;
  assign range_bad = (opA >= opM) || (opB >= opM) || (opM < WIDTH'(2));
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_q <= 1'b0;
    else if (load) err_q <= range_bad;
  end
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load  = 1'b1;
          acc_d = '0;
          cnt_d = CW'(WIDTH - 1);
          if (range_bad) begin
            state_d = DONE;
            out_d   = '0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        if (cnt_q == '0) begin
          state_d = DONE;
          out_d   = step;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      if (load) begin
        a_q <= opA;
        b_q <= opB;
        m_q <= opM;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

endmodule
